// File: rtl/dmem_lsu_port.sv
// dmem_lsu_port: byte-addressed data memory port for the core's MEM stage.
// Valid/ready request and response handshake, WAIT_STATES extra cycles of
// latency, RISC-V sized loads/stores with sign/zero extension, and error
// responses for out-of-range or illegal accesses.
// Build option: DMEM_MISALIGN_ERR_EN turns misaligned half/word accesses into
// error responses; without it they are silently aligned down.
// RAM words are stored XOR-ed with their own word index, so an all-zero
// power-up array reads back as word i = i without any initialisation logic.
module dmem_lsu_port #(
    parameter int DEPTH_WORDS = 1024,
    parameter int ADDR_W      = 32,
    parameter int WAIT_STATES = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err
);

    localparam int         IDX_W    = $clog2(DEPTH_WORDS);
    localparam logic [3:0] CNT_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t              state_r;
    state_t              state_s;
    logic [3:0]          cnt_r;
    logic                wr_r;
    logic [2:0]          f3_r;
    logic [ADDR_W-1:0]   addr_r;
    logic [31:0]         wdata_r;
    logic                req_ready_r;
    logic                rsp_valid_r;
    logic [31:0]         rsp_rdata_r;
    logic                rsp_err_r;
    logic [31:0]         mem_r [DEPTH_WORDS];

    logic                op_write_s;
    logic [2:0]          op_f3_s;
    logic [ADDR_W-1:0]   op_addr_s;
    logic [31:0]         op_wdata_s;
    logic [1:0]          size_s;
    logic                illegal_s;
    logic                oor_s;
    logic                misal_s;
    logic                err_s;
    logic [1:0]          lane_s;
    logic [IDX_W-1:0]    idx_s;
    logic [31:0]         scramble_s;
    logic [31:0]         raw_s;
    logic [31:0]         shifted_s;
    logic [31:0]         load_s;
    logic [3:0]          strobe_s;
    logic [31:0]         wlanes_s;
    logic                enter_resp_s;
    logic                mem_we_s;

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic: IDLE -> (WAIT ->) RESP -> IDLE.
    always_comb begin
        state_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (req_valid) begin
                    if (WAIT_STATES == 0) begin
                        state_s = S_RESP;
                    end else begin
                        state_s = S_WAIT;
                    end
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_WAIT: begin
                if (cnt_r == 4'd0) begin
                    state_s = S_RESP;
                end else begin
                    state_s = S_WAIT;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    state_s = S_IDLE;
                end else begin
                    state_s = S_RESP;
                end
            end
            default: state_s = S_IDLE;
        endcase
    end

    // Operand source: the live request when it goes straight to RESP from IDLE,
    // otherwise the copy latched at acceptance.
    always_comb begin
        op_write_s = wr_r;
        op_f3_s    = f3_r;
        op_addr_s  = addr_r;
        op_wdata_s = wdata_r;
        if (state_r == S_IDLE) begin
            op_write_s = req_write;
            op_f3_s    = req_funct3;
            op_addr_s  = req_addr;
            op_wdata_s = req_wdata;
        end else begin
            op_write_s = wr_r;
            op_f3_s    = f3_r;
            op_addr_s  = addr_r;
            op_wdata_s = wdata_r;
        end
    end

    // Access decode: legality, range, alignment, lane selection and strobes.
    always_comb begin
        size_s    = op_f3_s[1:0];
        illegal_s = (op_f3_s == 3'b011) || (op_f3_s[2:1] == 2'b11) ||
                    (op_f3_s[2] && op_write_s);
        oor_s     = (op_addr_s[ADDR_W-1:IDX_W+2] != {(ADDR_W-IDX_W-2){1'b0}});
        idx_s     = op_addr_s[IDX_W+1:2];
        misal_s   = 1'b0;
        lane_s    = op_addr_s[1:0];
        case (size_s)
            2'b01:   misal_s = op_addr_s[0];
            2'b10:   misal_s = (op_addr_s[1:0] != 2'b00);
            default: misal_s = 1'b0;
        endcase
`ifdef DMEM_MISALIGN_ERR_EN
        lane_s = op_addr_s[1:0];
        err_s  = oor_s || illegal_s || misal_s;
`else
        case (size_s)
            2'b01:   lane_s = {op_addr_s[1], 1'b0};
            2'b10:   lane_s = 2'b00;
            default: lane_s = op_addr_s[1:0];
        endcase
        err_s = oor_s || illegal_s;
`endif
        case (size_s)
            2'b00:   strobe_s = 4'b0001 << lane_s;
            2'b01:   strobe_s = 4'b0011 << lane_s;
            2'b10:   strobe_s = 4'b1111;
            default: strobe_s = 4'b0000;
        endcase
        case (size_s)
            2'b00:   wlanes_s = {4{op_wdata_s[7:0]}};
            2'b01:   wlanes_s = {2{op_wdata_s[15:0]}};
            default: wlanes_s = op_wdata_s;
        endcase
    end

    // Read path: unscramble the addressed word, shift the lane down, extend.
    always_comb begin
        scramble_s = {{(32-IDX_W){1'b0}}, idx_s};
        raw_s      = mem_r[idx_s] ^ scramble_s;
        shifted_s  = raw_s >> {lane_s, 3'b000};
        case (op_f3_s)
            3'b000:  load_s = {{24{shifted_s[7]}}, shifted_s[7:0]};
            3'b001:  load_s = {{16{shifted_s[15]}}, shifted_s[15:0]};
            3'b010:  load_s = shifted_s;
            3'b100:  load_s = {24'd0, shifted_s[7:0]};
            3'b101:  load_s = {16'd0, shifted_s[15:0]};
            default: load_s = 32'd0;
        endcase
        enter_resp_s = (state_s == S_RESP) && (state_r != S_RESP);
        mem_we_s     = enter_resp_s && op_write_s && !err_s;
    end

    // RAM write on the edge entering RESP; a reset at that edge cancels it.
    always_ff @(posedge clk) begin
        if (rst_n && mem_we_s) begin
            for (int b = 0; b < 4; b++) begin
                if (strobe_s[b]) begin
                    mem_r[idx_s][8*b +: 8] <= wlanes_s[8*b +: 8] ^ scramble_s[8*b +: 8];
                end
            end
        end
    end

    // Request latch, wait counter and registered response outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_r       <= 4'd0;
            wr_r        <= 1'b0;
            f3_r        <= 3'b000;
            addr_r      <= {ADDR_W{1'b0}};
            wdata_r     <= 32'd0;
            req_ready_r <= 1'b1;
            rsp_valid_r <= 1'b0;
            rsp_rdata_r <= 32'd0;
            rsp_err_r   <= 1'b0;
        end else begin
            req_ready_r <= (state_s == S_IDLE);
            rsp_valid_r <= (state_s == S_RESP);
            if ((state_r == S_IDLE) && req_valid) begin
                wr_r    <= req_write;
                f3_r    <= req_funct3;
                addr_r  <= req_addr;
                wdata_r <= req_wdata;
                cnt_r   <= CNT_INIT;
            end else if ((state_r == S_WAIT) && (cnt_r != 4'd0)) begin
                cnt_r <= cnt_r - 4'd1;
            end
            if (enter_resp_s) begin
                rsp_err_r   <= err_s;
                rsp_rdata_r <= (err_s || op_write_s) ? 32'd0 : load_s;
            end
        end
    end

    assign req_ready = req_ready_r;
    assign rsp_valid = rsp_valid_r;
    assign rsp_rdata = rsp_rdata_r;
    assign rsp_err   = rsp_err_r;

endmodule

// File: tb/tb_dmem_lsu_port.sv
// Bench for dmem_lsu_port: two instances (WAIT_STATES 0 and 3) checked against
// a byte-array reference model. Honours DMEM_MISALIGN_ERR_EN like the design.
module tb_dmem_lsu_port;

    logic             clk;
    logic             rst_n;
    logic [1:0]       req_valid;
    wire  [1:0]       req_ready;
    logic [1:0]       req_write;
    logic [1:0][2:0]  req_funct3;
    logic [1:0][31:0] req_addr;
    logic [1:0][31:0] req_wdata;
    wire  [1:0]       rsp_valid;
    logic [1:0]       rsp_ready;
    wire  [1:0][31:0] rsp_rdata;
    wire  [1:0]       rsp_err;

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0] mb [2][4096];

    dmem_lsu_port #(.DEPTH_WORDS(1024), .ADDR_W(32), .WAIT_STATES(0)) u0 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_write(req_write[0]),
        .req_funct3(req_funct3[0]), .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
        .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]), .rsp_rdata(rsp_rdata[0]),
        .rsp_err(rsp_err[0])
    );

    dmem_lsu_port #(.DEPTH_WORDS(1024), .ADDR_W(32), .WAIT_STATES(3)) u1 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_write(req_write[1]),
        .req_funct3(req_funct3[1]), .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
        .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]), .rsp_rdata(rsp_rdata[1]),
        .rsp_err(rsp_err[1])
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: memory as a little-endian byte array, accesses by byte count.
    function automatic void model(input int d, input logic wr, input logic [2:0] f3,
                                  input logic [31:0] addr, input logic [31:0] wd,
                                  output logic [31:0] erd, output logic eer);
        int          n;
        logic [31:0] a;
        logic [63:0] v;
        erd = 32'd0;
        eer = 1'b0;
        a   = addr;
        n   = 1 << f3[1:0];
        if (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7 || (f3 >= 3'd4 && wr)) begin
            eer = 1'b1;
        end else if (addr >= 32'd4096) begin
            eer = 1'b1;
        end else begin
            if ((a % n) != 0) begin
`ifdef DMEM_MISALIGN_ERR_EN
                eer = 1'b1;
`else
                a = a - (a % n);
`endif
            end
            if (!eer) begin
                if (wr) begin
                    for (int j = 0; j < n; j++) mb[d][a+j] = 8'(wd >> (8*j));
                end else begin
                    v = 64'd0;
                    for (int j = 0; j < n; j++) v = v | (64'(mb[d][a+j]) << (8*j));
                    if (f3 < 3'd4 && v[8*n-1]) v = v | ~((64'd1 << (8*n)) - 64'd1);
                    erd = v[31:0];
                end
            end
        end
    endfunction

    // Starts and ends at a negedge; returns captured response and latency.
    task automatic txn(input int d, input logic wr, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] wd, input int hold,
                       output logic [31:0] rd, output logic er, output int lat);
        logic busy_ok;
        logic stab_ok;
        chk("idle_ready", 32'(req_ready[d]), 32'd1);
        req_valid[d]  = 1'b1;
        req_write[d]  = wr;
        req_funct3[d] = f3;
        req_addr[d]   = addr;
        req_wdata[d]  = wd;
        @(posedge clk);
        @(negedge clk);
        req_valid[d] = 1'b0;
        lat     = 0;
        busy_ok = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            if (rsp_valid[d]) begin
                lat = k;
                break;
            end
            if (req_ready[d] !== 1'b0) busy_ok = 1'b0;
            @(negedge clk);
        end
        chk("busy_ready_low", 32'(busy_ok), 32'd1);
        rd = rsp_rdata[d];
        er = rsp_err[d];
        if (req_ready[d] !== 1'b0) busy_ok = 1'b0;
        stab_ok = 1'b1;
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            if (rsp_valid[d] !== 1'b1 || rsp_rdata[d] !== rd || rsp_err[d] !== er ||
                req_ready[d] !== 1'b0) stab_ok = 1'b0;
        end
        if (hold > 0) chk("resp_stable", 32'(stab_ok), 32'd1);
        rsp_ready[d] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rsp_ready[d] = 1'b0;
        chk("post_valid", 32'(rsp_valid[d]), 32'd0);
        chk("post_ready", 32'(req_ready[d]), 32'd1);
    endtask

    task automatic run(input int d, input logic wr, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] wd, input int hold,
                       output logic [31:0] rd);
        logic [31:0] erd;
        logic        eer;
        logic        er;
        int          lat;
        model(d, wr, f3, addr, wd, erd, eer);
        txn(d, wr, f3, addr, wd, hold, rd, er, lat);
        chk("rdata", rd, erd);
        chk("err", 32'(er), 32'(eer));
        chk("latency", 32'(lat), (d == 0) ? 32'd1 : 32'd4);
    endtask

    initial begin
        logic [31:0] rd;
        logic        wr;
        logic [2:0]  f3;
        logic [31:0] addr;
        clk        = 1'b0;
        rst_n      = 1'b0;
        req_valid  = '0;
        req_write  = '0;
        req_funct3 = '0;
        req_addr   = '0;
        req_wdata  = '0;
        rsp_ready  = '0;
        for (int d = 0; d < 2; d++)
            for (int i = 0; i < 4096; i++) mb[d][i] = 8'((i / 4) >> (8 * (i % 4)));

        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk("rst_req_ready", 32'(req_ready[d]), 32'd1);
            chk("rst_rsp_valid", 32'(rsp_valid[d]), 32'd0);
            chk("rst_rsp_rdata", rsp_rdata[d], 32'd0);
            chk("rst_rsp_err", 32'(rsp_err[d]), 32'd0);
        end
        rst_n = 1'b1;

        // Word store then load, zero wait states.
        run(0, 1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 0, rd);
        run(0, 1'b0, 3'b010, 32'h10, 32'd0, 0, rd);
        chk("t1_lw", rd, 32'hDEADBEEF);
        // Byte store, signed/unsigned byte loads, merged word.
        run(0, 1'b1, 3'b000, 32'h11, 32'h000000A5, 0, rd);
        run(0, 1'b0, 3'b000, 32'h11, 32'd0, 0, rd);
        chk("t2_lb", rd, 32'hFFFFFFA5);
        run(0, 1'b0, 3'b100, 32'h11, 32'd0, 0, rd);
        chk("t2_lbu", rd, 32'h000000A5);
        run(0, 1'b0, 3'b010, 32'h10, 32'd0, 0, rd);
        chk("t2_lw", rd, 32'hDEADA5EF);
        // Illegal and boundary addresses.
        run(0, 1'b1, 3'b100, 32'h20, 32'h11111111, 0, rd);
        run(0, 1'b0, 3'b111, 32'h20, 32'd0, 0, rd);
        run(0, 1'b0, 3'b010, 32'hFFC, 32'd0, 0, rd);
        chk("last_word", rd, 32'h000003FF);
        run(0, 1'b1, 3'b010, 32'h1000, 32'h22222222, 0, rd);
        run(0, 1'b0, 3'b010, 32'h1000, 32'd0, 0, rd);

        // Three wait states, fresh RAM.
        run(1, 1'b0, 3'b001, 32'h22, 32'd0, 0, rd);
        chk("t3_lh", rd, 32'h00000000);
        run(1, 1'b0, 3'b010, 32'h13, 32'd0, 0, rd);
`ifdef DMEM_MISALIGN_ERR_EN
        chk("t4_lw_mis", rd, 32'h00000000);
`else
        chk("t4_lw_mis", rd, 32'h00000004);
`endif
        run(1, 1'b0, 3'b010, 32'h0C, 32'd0, 5, rd);
        chk("t5_lw_hold", rd, 32'h00000003);

        // Reset during WAIT of a store: nothing commits.
        req_valid[1]  = 1'b1;
        req_write[1]  = 1'b1;
        req_funct3[1] = 3'b010;
        req_addr[1]   = 32'h40;
        req_wdata[1]  = 32'h12345678;
        @(posedge clk);
        @(negedge clk);
        req_valid[1] = 1'b0;
        chk("t6_wait_ready", 32'(req_ready[1]), 32'd0);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("t6_rst_ready", 32'(req_ready[1]), 32'd1);
        chk("t6_rst_valid", 32'(rsp_valid[1]), 32'd0);
        chk("t6_rst_rdata", rsp_rdata[1], 32'd0);
        chk("t6_rst_err", 32'(rsp_err[1]), 32'd0);
        rst_n = 1'b1;
        run(1, 1'b0, 3'b010, 32'h40, 32'd0, 0, rd);
        chk("t6_lw", rd, 32'h00000010);

        // Randomized mix on both instances.
        for (int i = 0; i < 160; i++) begin
            wr   = 1'($urandom_range(0, 1));
            f3   = 3'($urandom_range(0, 7));
            addr = ($urandom_range(0, 9) == 0) ? $urandom : 32'($urandom_range(0, 95));
            run(i % 2, wr, f3, addr, $urandom, $urandom_range(0, 2), rd);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
